// File: rtl/hdmi_timing_gen_if.sv
// Pixel-side bundle between the raster timing generator, the RGB frame
// buffer and the TMDS encoder.
//   HDMIdata   : pixel returned by the frame buffer
//   HVsync     : high during active lines (buffer read-address reset when low)
//   HMemRead   : frame-buffer read strobe, one per active pixel
//   pVDE       : data enable aligned with RGB_out
//   HSync      : horizontal sync aligned with pVDE
//   VSync      : vertical sync aligned with pVDE
//   RGB_out    : blank-gated pixel to the encoder
//   FrameStart : one-clock pulse on the first active pixel of a frame
// master = timing generator side, slave = buffer/encoder side.
interface hdmi_timing_gen_if;
  logic [23:0] HDMIdata;
  logic        HVsync;
  logic        HMemRead;
  logic        pVDE;
  logic        HSync;
  logic        VSync;
  logic [23:0] RGB_out;
  logic        FrameStart;

  modport master (
    input  HDMIdata,
    output HVsync, HMemRead, pVDE, HSync, VSync, RGB_out, FrameStart
  );

  modport slave (
    output HDMIdata,
    input  HVsync, HMemRead, pVDE, HSync, VSync, RGB_out, FrameStart
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator (default 640x480@60) on the pixel clock Hclk.
// Issues frame-buffer reads (HMemRead/HVsync) one clock after the raster
// counters, then delays the region flags by READ_LEAD more clocks so that
// pVDE/HSync/VSync/FrameStart line up with the pixel that comes back from
// the buffer, which is registered onto RGB_out (zero outside active video).
// Ports:
//   Hclk  : pixel clock
//   rstn  : asynchronous active-low reset
//   en    : timing enable; low holds the raster at its origin
//   hdmi  : hdmi_timing_gen_if master (buffer read side + encoder side)
module hdmi_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned READ_LEAD = 1
) (
  input logic               Hclk,
  input logic               rstn,
  input logic               en,
  hdmi_timing_gen_if.master hdmi
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcnt;
  logic [9:0]  vcnt;

  // Stage-0 region flags, straight from the counters
  logic act, hs, vs, va, first;

  // Index 0 is the read-issue stage (drives HMemRead); index READ_LEAD is
  // the encoder-facing stage.
  logic [READ_LEAD:0] act_d;
  logic [READ_LEAD:0] hs_d;
  logic [READ_LEAD:0] vs_d;
  logic [READ_LEAD:0] first_d;
  logic               va_q;
  logic [23:0]        rgb_q;

  // Raster counters; dropping en snaps them back to the origin.
  always_ff @(posedge Hclk or negedge rstn) begin
    if (!rstn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  always_comb begin
    act   = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs    = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    vs    = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    va    = (vcnt < V_ACT);
    first = (hcnt == '0) && (vcnt == '0);
  end

  // Stage-0 flags are gated with en: while disabled the counters sit at the
  // origin, which would otherwise look like a permanent first pixel.
  always_ff @(posedge Hclk or negedge rstn) begin
    if (!rstn) begin
      act_d   <= '0;
      hs_d    <= '0;
      vs_d    <= '0;
      first_d <= '0;
      va_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      act_d[0]   <= en & act;
      hs_d[0]    <= en & hs;
      vs_d[0]    <= en & vs;
      first_d[0] <= en & first;
      va_q       <= en & va;

      act_d[READ_LEAD:1]   <= act_d[READ_LEAD-1:0];
      hs_d[READ_LEAD:1]    <= hs_d[READ_LEAD-1:0];
      vs_d[READ_LEAD:1]    <= vs_d[READ_LEAD-1:0];
      first_d[READ_LEAD:1] <= first_d[READ_LEAD-1:0];

      // Loaded on the same edge that moves act_d[READ_LEAD-1] into
      // act_d[READ_LEAD], so RGB_out and pVDE change together.
      rgb_q <= act_d[READ_LEAD-1] ? hdmi.HDMIdata : '0;
    end
  end

  assign hdmi.HMemRead   = act_d[0];
  assign hdmi.HVsync     = va_q;
  assign hdmi.pVDE       = act_d[READ_LEAD];
  assign hdmi.HSync      = hs_d[READ_LEAD] ^ ~SYNC_POL;
  assign hdmi.VSync      = vs_d[READ_LEAD] ^ ~SYNC_POL;
  assign hdmi.FrameStart = first_d[READ_LEAD];
  assign hdmi.RGB_out    = rgb_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: one default-parameter instance and two small
// rasters (READ_LEAD 1 / active-low sync, READ_LEAD 3 / active-high sync).
// Expected outputs come from a position-based reference: each enabled clock
// advances a linear pixel position, the raster coordinate is derived with
// division/modulo, and outputs are looked up from the edge-indexed history.
module tb_hdmi_timing_gen;

  logic        Hclk = 1'b0;
  logic        rstn;
  logic        en;
  logic [23:0] data [3];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 Hclk = ~Hclk;

  hdmi_timing_gen_if if0 ();
  hdmi_timing_gen_if if1 ();
  hdmi_timing_gen_if if2 ();

  assign if0.HDMIdata = data[0];
  assign if1.HDMIdata = data[1];
  assign if2.HDMIdata = data[2];

  hdmi_timing_gen u_def (
    .Hclk (Hclk),
    .rstn (rstn),
    .en   (en),
    .hdmi (if0)
  );

  hdmi_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .READ_LEAD(1)
  ) u_s1 (
    .Hclk (Hclk),
    .rstn (rstn),
    .en   (en),
    .hdmi (if1)
  );

  hdmi_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .READ_LEAD(3)
  ) u_s3 (
    .Hclk (Hclk),
    .rstn (rstn),
    .en   (en),
    .hdmi (if2)
  );

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, pol, lead;
  } cfg_t;

  typedef struct packed {
    logic act, hs, vs, first, va;
  } tup_t;

  typedef struct packed {
    logic        mr, hv, de, hs, vs, fs;
    logic [23:0] rgb;
  } out_t;

  function automatic cfg_t cfg(int i);
    cfg_t c;
    if (i == 0) c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1};
    else        c = '{16, 2, 4, 3, 6, 1, 2, 2, (i == 2) ? 1 : 0, (i == 2) ? 3 : 1};
    return c;
  endfunction

  function automatic int htot(int i);
    cfg_t c = cfg(i);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int vtot(int i);
    cfg_t c = cfg(i);
    return c.va + c.vf + c.vs + c.vb;
  endfunction

  function automatic int lead(int i);
    cfg_t c = cfg(i);
    return c.lead;
  endfunction

  // Region flags for linear pixel position p of instance i
  function automatic tup_t ideal(int i, int p);
    cfg_t c = cfg(i);
    int   h = p % htot(i);
    int   v = p / htot(i);
    tup_t t;
    t.act   = (h < c.ha) && (v < c.va);
    t.hs    = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
    t.vs    = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
    t.first = (p == 0);
    t.va    = (v < c.va);
    return t;
  endfunction

  // Reference state: position counter and flags of the last five edges
  int          pos   [3];
  tup_t        hist  [3][5];
  logic [23:0] rgb_e [3];

  always @(posedge Hclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        pos[i]   <= 0;
        rgb_e[i] <= '0;
        for (int k = 0; k < 5; k++) hist[i][k] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        pos[i]     <= en ? (pos[i] + 1) % (htot(i) * vtot(i)) : 0;
        hist[i][0] <= en ? ideal(i, pos[i]) : '0;
        for (int k = 1; k < 5; k++) hist[i][k] <= hist[i][k-1];
        // pixel returned now belongs to the flags issued lead() edges ago
        rgb_e[i] <= hist[i][lead(i)-1].act ? data[i] : '0;
      end
    end
  end

  function automatic out_t expect_o(int i);
    cfg_t c   = cfg(i);
    tup_t s   = hist[i][c.lead];
    logic pol = (c.pol != 0);
    out_t e;
    e.mr  = hist[i][0].act;
    e.hv  = hist[i][0].va;
    e.de  = s.act;
    e.hs  = s.hs ? pol : ~pol;
    e.vs  = s.vs ? pol : ~pol;
    e.fs  = s.first;
    e.rgb = rgb_e[i];
    return e;
  endfunction

  out_t obs_w [3];
  assign obs_w[0] = {if0.HMemRead, if0.HVsync, if0.pVDE, if0.HSync, if0.VSync, if0.FrameStart, if0.RGB_out};
  assign obs_w[1] = {if1.HMemRead, if1.HVsync, if1.pVDE, if1.HSync, if1.VSync, if1.FrameStart, if1.RGB_out};
  assign obs_w[2] = {if2.HMemRead, if2.HVsync, if2.pVDE, if2.HSync, if2.VSync, if2.FrameStart, if2.RGB_out};

  task automatic check_all(string tag);
    out_t o, e;
    for (int i = 0; i < 3; i++) begin
      o = obs_w[i];
      e = expect_o(i);
      total++;
      assert (o === e) passed++;
      else begin
        fails++;
        $error("FAIL %s dut%0d t=%0t obs mr=%b hv=%b de=%b hs=%b vs=%b fs=%b rgb=%h exp mr=%b hv=%b de=%b hs=%b vs=%b fs=%b rgb=%h",
               tag, i, $time, o.mr, o.hv, o.de, o.hs, o.vs, o.fs, o.rgb,
               e.mr, e.hv, e.de, e.hs, e.vs, e.fs, e.rgb);
      end
    end
  endtask

  task automatic cnt_chk(string tag, int got, int exp);
    total++;
    assert (got == exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] rnd_pix();
    return ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 3; i++) data[i] = rnd_pix();
  endtask

  // Start from the origin (en low beforehand) and run one frame of the small
  // rasters plus the first line of the default raster, counting events.
  task automatic frame_counts(string tag);
    int   n_mr [3], n_de [3], n_vs [3], n_hvl [3], n_fs [3];
    int   mr_rise [3], de_rise [3];
    int   rise0 [$];
    int   mr_hi0 = 0, hs_act0 = 0, hs_first0 = -1;
    logic prev_mr0 = 1'b0;
    cfg_t c;
    out_t o;
    for (int i = 0; i < 3; i++) begin
      n_mr[i] = 0; n_de[i] = 0; n_vs[i] = 0; n_hvl[i] = 0; n_fs[i] = 0;
      mr_rise[i] = -1; de_rise[i] = -1;
    end
    en = 1'b1;
    for (int cyc = 1; cyc <= 900; cyc++) begin
      @(negedge Hclk);
      check_all(tag);
      for (int i = 1; i < 3; i++) begin
        c = cfg(i);
        o = obs_w[i];
        if (cyc <= htot(i) * vtot(i)) begin
          n_mr[i]  += int'(o.mr);
          n_hvl[i] += int'(!o.hv);
          if (o.mr && mr_rise[i] < 0) mr_rise[i] = cyc;
        end
        if (cyc > c.lead && cyc <= htot(i) * vtot(i) + c.lead) begin
          n_de[i] += int'(o.de);
          n_vs[i] += int'(o.vs == (c.pol != 0));
          n_fs[i] += int'(o.fs);
          if (o.de && de_rise[i] < 0) de_rise[i] = cyc;
        end
      end
      o = obs_w[0];
      if (o.mr && !prev_mr0) rise0.push_back(cyc);
      prev_mr0 = o.mr;
      if (cyc <= 800) mr_hi0 += int'(o.mr);
      if (cyc >= 2 && cyc <= 801 && !o.hs) begin
        hs_act0++;
        if (hs_first0 < 0) hs_first0 = cyc;
      end
      drive_data();
    end
    for (int i = 1; i < 3; i++) begin
      c = cfg(i);
      cnt_chk($sformatf("%s_mr_count_dut%0d", tag, i), n_mr[i], c.ha * c.va);
      cnt_chk($sformatf("%s_de_count_dut%0d", tag, i), n_de[i], c.ha * c.va);
      cnt_chk($sformatf("%s_vsync_clks_dut%0d", tag, i), n_vs[i], c.vs * htot(i));
      cnt_chk($sformatf("%s_hvsync_low_dut%0d", tag, i), n_hvl[i], (vtot(i) - c.va) * htot(i));
      cnt_chk($sformatf("%s_framestart_dut%0d", tag, i), n_fs[i], 1);
      cnt_chk($sformatf("%s_de_lead_dut%0d", tag, i), de_rise[i] - mr_rise[i], c.lead);
    end
    cnt_chk({tag, "_mr_first_rise_def"}, (rise0.size() > 0) ? rise0[0] : -1, 1);
    cnt_chk({tag, "_line_period_def"}, (rise0.size() > 1) ? rise0[1] - rise0[0] : -1, 640 + 16 + 96 + 48);
    cnt_chk({tag, "_mr_width_def"}, mr_hi0, 640);
    cnt_chk({tag, "_hsync_width_def"}, hs_act0, 96);
    cnt_chk({tag, "_hsync_fall_def"}, hs_first0, 1 + 656 + 1);
  endtask

  initial begin
    bit found;
    rstn = 1'b0;
    en   = 1'b0;
    for (int i = 0; i < 3; i++) data[i] = 24'hFFFFFF;

    // reset state
    repeat (3) begin
      @(negedge Hclk);
      check_all("reset");
    end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge Hclk);
      check_all("idle");
      drive_data();
    end

    frame_counts("frame1");

    // random enable drops (including mid-line) with random buffer data
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge Hclk);
      check_all("random");
      drive_data();
      if (en) en = ($urandom_range(0, 119) != 0);
      else    en = ($urandom_range(0, 3) == 0);
    end

    // asynchronous reset in the middle of an active line
    en = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge Hclk);
      check_all("seek_active");
      drive_data();
      found = (if1.HMemRead === 1'b1) && (if2.pVDE === 1'b1);
    end
    total++;
    assert (found) passed++;
    else begin
      fails++;
      $error("FAIL seek_active_timeout obs=%b exp=%b", found, 1'b1);
    end
    #2 rstn = 1'b0;
    #1 check_all("async_reset");
    en = 1'b0;
    @(negedge Hclk);
    check_all("held_reset");
    rstn = 1'b1;
    @(negedge Hclk);
    check_all("post_release");

    frame_counts("frame2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
